lc3_mem_responder: RTL
======================

// Module: lc3_mem_responder
// PURPOSE
//  Memory-side responder for the LC3 core's instruction and data memory interface.
//  Services instruction fetches and data reads/writes from one shared single-port word array.
//  Returns data with programmable per-channel latency and one-cycle completion pulses.
//  Used as the synthesizable memory model beneath the LC3 DUT; the bench preloads it via a load port.
// PARAMETERS
//  ADDR_W      16  address width of pc / Data_addr
//  DATA_W      16  word width
//  DEPTH_LOG2  8   array holds 2**DEPTH_LOG2 words; only addr[DEPTH_LOG2-1:0] is used (aliasing)
//  INSTR_LAT   2   cycles from accepted fetch to complete_instr (legal 1..15)
//  DATA_LAT    3   cycles from accepted data access to complete_data (legal 1..15)
// PORTS
//  clock          in   1       single clock, all logic on rising edge
//  reset          in   1       synchronous, active-high
//  instrmem_rd    in   1       fetch request, level; sampled only when instr channel IDLE
//  pc             in   ADDR_W  fetch address, latched on accept
//  Instr_dout     out  DATA_W  fetched word, valid in complete_instr cycle, held until next fetch completes
//  complete_instr out  1       one-cycle pulse: fetch done
//  Data_rd        in   1       data read request, level
//  Data_wr        in   1       data write request, level
//  Data_addr      in   ADDR_W  data address, latched on accept
//  Data_din       in   DATA_W  write data (core->memory), latched on accept
//  Data_dout      out  DATA_W  read word, valid in complete_data cycle, held until next read completes
//  complete_data  out  1       one-cycle pulse: data read or write done
//  ld_en          in   1       bench preload strobe: mem[ld_addr] <= ld_data
//  ld_addr        in   ADDR_W  preload address
//  ld_data        in   DATA_W  preload data
//  err            out  1       sticky: illegal request seen; cleared only by reset
// BEHAVIOUR
//  - Reset: Instr_dout=0, Data_dout=0, complete_*=0, err=0, both FSMs IDLE, counters 0.
//    Array contents NOT cleared.
//  - Reset asserted mid-transaction aborts it: no complete pulse and no array write.
//  - Per channel FSM: IDLE -> WAIT -> ACCESS -> IDLE.
//  - IDLE: on request, latch address (and Data_din, and op=wr/rd for the data channel), load cnt=LAT-1,
//    go to WAIT; if LAT=1 go directly to ACCESS.
//  - WAIT: decrement cnt; at cnt==1 go to ACCESS.
//  - ACCESS: perform array op. Register output and pulse complete the SAME cycle as the array op.
//    Then go to IDLE. Net latency: request sampled in cycle N -> complete high in cycle N+LAT.
//  - IDLE is held >=1 cycle after complete; a request still high then is a NEW request (back-to-back period LAT+1).
//  - Port conflict: both channels in ACCESS the same cycle -> data wins; instr stays in ACCESS one extra
//    cycle (its latency +1). No other stalls.
//  - Read-during-write to same word in same cycle cannot occur (single access/cycle).
//    A fetch after a write completes sees the new data.
//  - Data_rd & Data_wr both high in IDLE: request ignored, err<=1.
//  - ld_en: accepted only when both channels IDLE and no request being accepted this cycle.
//    ld_en while busy, or in the same cycle as a request: load dropped, err<=1.
//  - Address aliasing: addr bits above DEPTH_LOG2 ignored (0x0105 == 0x0005 for DEPTH_LOG2=8).
//  - Request lines changing while channel busy are ignored; latched values are used.
// TESTING
//  1. Preload mem[0x3000]=0x1234; fetch pc=0x3000 at cycle 10 -> complete_instr at cycle 12 (INSTR_LAT=2),
//     Instr_dout=0x1234.
//  2. Data_wr addr 0x0040 din 0xBEEF at cycle 5 -> complete_data at 8.
//     Then Data_rd 0x0040 at 9 -> complete_data at 12, Data_dout=0xBEEF.
//  3. Collision: fetch at cycle 1, data read at cycle 0 (both reach ACCESS at 3) -> complete_data at 3,
//     complete_instr at 4.
//  4. Data_rd=Data_wr=1 in IDLE -> no complete_data, err=1 and sticky until reset.
//     ld_en during a fetch -> load dropped, err=1.
//  5. Reset pulse during WAIT of a write to 0x0010 (old 0x0000) -> no complete_data; read 0x0010 returns 0x0000.
//  6. instrmem_rd held high for 9 cycles from cycle 0 -> complete_instr at cycles 2, 5, 8; pc 0x0105 aliases 0x0005.

Source files
------------

// File: rtl/lc3_mem_responder_if.sv
// Bus bundle between the LC3 core (master) and its memory responder (slave).
// Carries the fetch channel, the data channel and the bench preload port.
interface lc3_mem_responder_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              instrmem_rd;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] Instr_dout;
  logic              complete_instr;
  logic              Data_rd;
  logic              Data_wr;
  logic [ADDR_W-1:0] Data_addr;
  logic [DATA_W-1:0] Data_din;
  logic [DATA_W-1:0] Data_dout;
  logic              complete_data;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              err;

  modport master (
    output instrmem_rd, pc, Data_rd, Data_wr, Data_addr, Data_din, ld_en, ld_addr, ld_data,
    input  Instr_dout, complete_instr, Data_dout, complete_data, err
  );

  modport slave (
    input  instrmem_rd, pc, Data_rd, Data_wr, Data_addr, Data_din, ld_en, ld_addr, ld_data,
    output Instr_dout, complete_instr, Data_dout, complete_data, err
  );
endinterface

// File: rtl/lc3_mem_responder.sv
// Single-port word memory serving an instruction channel and a data channel, each with its own
// fixed latency. The array op is committed on the edge that enters a channel's ACCESS cycle.
module lc3_mem_responder #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned INSTR_LAT  = 2,
  parameter int unsigned DATA_LAT   = 3
) (
  input logic                clock,
  input logic                reset,
  lc3_mem_responder_if.slave bus
);
  localparam int unsigned Depth     = 2 ** DEPTH_LOG2;
  localparam logic [3:0]  InstrCnt0 = 4'(INSTR_LAT - 1);
  localparam logic [3:0]  DataCnt0  = 4'(DATA_LAT - 1);

  // StStall: instr lost the single port to data and retries on the next edge.
  typedef enum logic [1:0] {StIdle, StWait, StStall, StAccess} state_e;

  state_e                i_st_q, i_st_d, d_st_q, d_st_d;
  logic [3:0]            i_cnt_q, i_cnt_d, d_cnt_q, d_cnt_d;
  logic [DEPTH_LOG2-1:0] i_addr_q, i_addr_d, d_addr_q, d_addr_d;
  logic [DATA_W-1:0]     d_din_q, d_din_d;
  logic                  d_wr_q, d_wr_d;
  logic [DATA_W-1:0]     instr_dout_q, instr_dout_d, data_dout_q, data_dout_d;
  logic                  err_q, err_d;

  logic [DATA_W-1:0]     mem_q [Depth];
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_waddr;
  logic [DATA_W-1:0]     mem_wdata;

  logic                  i_acc, i_go, i_commit, d_idle, d_acc, d_bad, d_go, d_op_wr, ld_ok;
  logic [DEPTH_LOG2-1:0] i_idx, d_idx;
  logic [DATA_W-1:0]     d_wdata;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{bus.pc[ADDR_W-1:DEPTH_LOG2], bus.Data_addr[ADDR_W-1:DEPTH_LOG2],
                              bus.ld_addr[ADDR_W-1:DEPTH_LOG2]};

  always_comb begin
    i_acc    = (i_st_q == StIdle) && bus.instrmem_rd;
    d_idle   = (d_st_q == StIdle);
    d_acc    = d_idle && (bus.Data_rd ^ bus.Data_wr);
    d_bad    = d_idle && bus.Data_rd && bus.Data_wr;
    i_go     = (i_acc && (INSTR_LAT == 1)) || ((i_st_q == StWait) && (i_cnt_q == 4'd1)) ||
               (i_st_q == StStall);
    d_go     = (d_acc && (DATA_LAT == 1)) || ((d_st_q == StWait) && (d_cnt_q == 4'd1));
    i_commit = i_go && !d_go;
    // A latency of 1 commits straight from idle, before the request fields are latched.
    i_idx    = (i_st_q == StIdle) ? bus.pc[DEPTH_LOG2-1:0] : i_addr_q;
    d_idx    = d_idle ? bus.Data_addr[DEPTH_LOG2-1:0] : d_addr_q;
    d_op_wr  = d_idle ? bus.Data_wr : d_wr_q;
    d_wdata  = d_idle ? bus.Data_din : d_din_q;
    ld_ok    = bus.ld_en && (i_st_q == StIdle) && d_idle &&
               !bus.instrmem_rd && !bus.Data_rd && !bus.Data_wr;
  end

  always_comb begin
    i_st_d   = i_st_q;
    i_cnt_d  = i_cnt_q;
    i_addr_d = i_addr_q;
    unique case (i_st_q)
      StIdle: begin
        if (i_acc) begin
          i_st_d   = StWait;
          i_cnt_d  = InstrCnt0;
          i_addr_d = i_idx;
        end
      end
      StWait:   i_cnt_d = i_cnt_q - 4'd1;
      StStall:  i_st_d  = StStall;
      StAccess: i_st_d  = StIdle;
    endcase
    if (i_go) i_st_d = i_commit ? StAccess : StStall;

    d_st_d   = d_st_q;
    d_cnt_d  = d_cnt_q;
    d_addr_d = d_addr_q;
    d_din_d  = d_din_q;
    d_wr_d   = d_wr_q;
    unique case (d_st_q)
      StIdle: begin
        if (d_acc) begin
          d_st_d   = StWait;
          d_cnt_d  = DataCnt0;
          d_addr_d = d_idx;
          d_din_d  = d_wdata;
          d_wr_d   = d_op_wr;
        end
      end
      StWait:   d_cnt_d = d_cnt_q - 4'd1;
      StStall:  d_st_d  = StIdle;
      StAccess: d_st_d  = StIdle;
    endcase
    if (d_go) d_st_d = StAccess;

    instr_dout_d = i_commit ? mem_q[i_idx] : instr_dout_q;
    data_dout_d  = (d_go && !d_op_wr) ? mem_q[d_idx] : data_dout_q;
    err_d        = err_q || d_bad || (bus.ld_en && !ld_ok);

    mem_we    = !reset && ((d_go && d_op_wr) || ld_ok);
    mem_waddr = ld_ok ? bus.ld_addr[DEPTH_LOG2-1:0] : d_idx;
    mem_wdata = ld_ok ? bus.ld_data : d_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      i_st_q       <= StIdle;
      d_st_q       <= StIdle;
      i_cnt_q      <= '0;
      d_cnt_q      <= '0;
      i_addr_q     <= '0;
      d_addr_q     <= '0;
      d_din_q      <= '0;
      d_wr_q       <= 1'b0;
      instr_dout_q <= '0;
      data_dout_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      i_st_q       <= i_st_d;
      d_st_q       <= d_st_d;
      i_cnt_q      <= i_cnt_d;
      d_cnt_q      <= d_cnt_d;
      i_addr_q     <= i_addr_d;
      d_addr_q     <= d_addr_d;
      d_din_q      <= d_din_d;
      d_wr_q       <= d_wr_d;
      instr_dout_q <= instr_dout_d;
      data_dout_q  <= data_dout_d;
      err_q        <= err_d;
    end
  end

  // Contents survive reset; the bench preloads through the ld port.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign bus.Instr_dout     = instr_dout_q;
  assign bus.Data_dout      = data_dout_q;
  assign bus.complete_instr = (i_st_q == StAccess);
  assign bus.complete_data  = (d_st_q == StAccess);
  assign bus.err            = err_q;
endmodule
